// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle from vga_timing_gen to the pixel generator and VGA pins.
// master = timing generator, slave = consumer.
interface vga_timing_gen_if #(
    parameter int unsigned CW = 11
);
    logic          p_tick;
    logic [CW-1:0] x;
    logic [CW-1:0] y;
    logic          video_on;
    logic          hsync;
    logic          vsync;
    logic          line_start;
    logic          frame_start;

    modport master (
        output p_tick, x, y, video_on, hsync, vsync, line_start, frame_start
    );

    modport slave (
        input  p_tick, x, y, video_on, hsync, vsync, line_start, frame_start
    );
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised VGA/VESA raster timing generator with a pixel clock-enable divider.
// Optional macro VGA_SYNC_DLY_EN adds SYNC_DLY p_tick-advanced delay stages on hsync/vsync/video_on.
module vga_timing_gen #(
    parameter int unsigned CLK_DIV = 4,
    parameter int unsigned HD      = 640,
    parameter int unsigned HF      = 16,
    parameter int unsigned HR      = 96,
    parameter int unsigned HB      = 48,
    parameter int unsigned VD      = 480,
    parameter int unsigned VF      = 10,
    parameter int unsigned VR      = 2,
    parameter int unsigned VB      = 33,
    parameter logic        H_POL   = 1'b0,
    parameter logic        V_POL   = 1'b0,
    parameter int unsigned CW      = 11
`ifdef VGA_SYNC_DLY_EN
    ,
    parameter int unsigned SYNC_DLY = 2
`endif
) (
    input  logic              clk_100MHz,
    input  logic              reset,
    input  logic              en,
    vga_timing_gen_if.master  vga
);

    localparam int unsigned HMAX   = HD + HF + HR + HB - 1;
    localparam int unsigned VMAX   = VD + VF + VR + VB - 1;
    localparam int unsigned HS_ON  = HD + HF;
    localparam int unsigned HS_OFF = HD + HF + HR - 1;
    localparam int unsigned VS_ON  = VD + VF;
    localparam int unsigned VS_OFF = VD + VF + VR - 1;
    localparam int unsigned DW     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [CW-1:0] HMAX_C   = CW'(HMAX);
    localparam logic [CW-1:0] VMAX_C   = CW'(VMAX);
    localparam logic [CW-1:0] HD_C     = CW'(HD);
    localparam logic [CW-1:0] VD_C     = CW'(VD);
    localparam logic [CW-1:0] HS_ON_C  = CW'(HS_ON);
    localparam logic [CW-1:0] HS_OFF_C = CW'(HS_OFF);
    localparam logic [CW-1:0] VS_ON_C  = CW'(VS_ON);
    localparam logic [CW-1:0] VS_OFF_C = CW'(VS_OFF);

    generate
        if (CLK_DIV < 1) begin : g_chk_div
            $error("vga_timing_gen: CLK_DIV must be >= 1");
        end
        if (HD < 1 || HF < 1 || HR < 1 || HB < 1) begin : g_chk_h
            $error("vga_timing_gen: horizontal display/porch/sync widths must be >= 1");
        end
        if (VD < 1 || VF < 1 || VR < 1 || VB < 1) begin : g_chk_v
            $error("vga_timing_gen: vertical display/porch/sync widths must be >= 1");
        end
        if (CW < 1 || CW > 31 || (HMAX >> CW) != 0 || (VMAX >> CW) != 0) begin : g_chk_cw
            $error("vga_timing_gen: CW too narrow for HMAX/VMAX");
        end
    endgenerate

    logic [DW-1:0] div_q;
    logic          tick;
    logic [CW-1:0] x_q, y_q;
    logic [CW-1:0] x_nxt, y_nxt;
    logic          vid_d, hs_d, vs_d;
    logic          vid_q, hs_q, vs_q;

    // Pixel-rate enable; with CLK_DIV=1 div_q is stuck at 0 so tick follows en.
    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            div_q <= '0;
        end else if (en) begin
            div_q <= (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
        end
    end

    assign tick = en & (div_q == DIV_LAST);

    always_comb begin
        x_nxt = x_q;
        y_nxt = y_q;
        if (tick) begin
            if (x_q == HMAX_C) begin
                x_nxt = '0;
                y_nxt = (y_q == VMAX_C) ? '0 : y_q + 1'b1;
            end else begin
                x_nxt = x_q + 1'b1;
            end
        end
    end

    // Decode from next-state counters so the registered flags line up with x/y.
    always_comb begin
        vid_d = (x_nxt < HD_C) && (y_nxt < VD_C);
        hs_d  = ((x_nxt >= HS_ON_C) && (x_nxt <= HS_OFF_C)) ? H_POL : ~H_POL;
        vs_d  = ((y_nxt >= VS_ON_C) && (y_nxt <= VS_OFF_C)) ? V_POL : ~V_POL;
    end

    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            x_q   <= '0;
            y_q   <= '0;
            vid_q <= 1'b1;
            hs_q  <= ~H_POL;
            vs_q  <= ~V_POL;
        end else if (tick) begin
            x_q   <= x_nxt;
            y_q   <= y_nxt;
            vid_q <= vid_d;
            hs_q  <= hs_d;
            vs_q  <= vs_d;
        end
    end

`ifdef VGA_SYNC_DLY_EN
    generate
        if (SYNC_DLY < 1) begin : g_chk_dly
            $error("vga_timing_gen: SYNC_DLY must be >= 1");
        end
    endgenerate

    logic [SYNC_DLY-1:0] hs_pipe, vs_pipe, vid_pipe;

    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            hs_pipe  <= {SYNC_DLY{~H_POL}};
            vs_pipe  <= {SYNC_DLY{~V_POL}};
            vid_pipe <= '0;
        end else if (tick) begin
            hs_pipe[0]  <= hs_q;
            vs_pipe[0]  <= vs_q;
            vid_pipe[0] <= vid_q;
            for (int unsigned i = 1; i < SYNC_DLY; i++) begin
                hs_pipe[i]  <= hs_pipe[i-1];
                vs_pipe[i]  <= vs_pipe[i-1];
                vid_pipe[i] <= vid_pipe[i-1];
            end
        end
    end

    assign vga.hsync    = hs_pipe[SYNC_DLY-1];
    assign vga.vsync    = vs_pipe[SYNC_DLY-1];
    assign vga.video_on = vid_pipe[SYNC_DLY-1];
`else
    assign vga.hsync    = hs_q;
    assign vga.vsync    = vs_q;
    assign vga.video_on = vid_q;
`endif

    assign vga.p_tick      = tick;
    assign vga.x           = x_q;
    assign vga.y           = y_q;
    assign vga.line_start  = tick & (x_q == '0);
    assign vga.frame_start = tick & (x_q == '0) & (y_q == '0);

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen: two small-raster instances (CLK_DIV=3 and CLK_DIV=1)
// checked every clock against a pixel-count reference model.
module tb_vga_timing_gen;

    localparam int HT  = 16;   // 8+2+3+3
    localparam int VT  = 7;    // 4+1+1+1
    localparam int FRM = HT * VT;

    logic clk_100MHz = 1'b0;
    logic reset      = 1'b1;
    logic en         = 1'b0;

    always #5 clk_100MHz = ~clk_100MHz;

    vga_timing_gen_if #(.CW(5)) vga0 ();
    vga_timing_gen_if #(.CW(5)) vga1 ();

    vga_timing_gen #(
        .CLK_DIV(3), .HD(8), .HF(2), .HR(3), .HB(3),
        .VD(4), .VF(1), .VR(1), .VB(1),
        .H_POL(1'b0), .V_POL(1'b1), .CW(5)
    ) dut0 (
        .clk_100MHz(clk_100MHz), .reset(reset), .en(en), .vga(vga0)
    );

    vga_timing_gen #(
        .CLK_DIV(1), .HD(8), .HF(2), .HR(3), .HB(3),
        .VD(4), .VF(1), .VR(1), .VB(1),
        .H_POL(1'b1), .V_POL(1'b1), .CW(5)
    ) dut1 (
        .clk_100MHz(clk_100MHz), .reset(reset), .en(en), .vga(vga1)
    );

    typedef struct {
        logic       pt;
        logic [4:0] x;
        logic [4:0] y;
        logic       vid;
        logic       hs;
        logic       vs;
        logic       ls;
        logic       fs;
    } exp_t;

    exp_t sbq0[$];
    exp_t sbq1[$];

    int tests  = 0;
    int failed = 0;
    logic mon_on = 1'b0;

    // Reference state: enabled edges and pixel ticks since reset, per instance.
    int unsigned e_cnt[2];
    int unsigned p_cnt[2];
`ifdef VGA_SYNC_DLY_EN
    logic ph[2][2];
    logic pv[2][2];
    logic pd[2][2];
`endif

    function automatic int unsigned div_of(input int k);
        return (k == 0) ? 3 : 1;
    endfunction

    function automatic logic hpol_of(input int k);
        return (k == 0) ? 1'b0 : 1'b1;
    endfunction

    function automatic logic hs_of(input int k, input int unsigned p);
        int unsigned xx = p % HT;
        return (xx >= 10 && xx <= 12) ? hpol_of(k) : ~hpol_of(k);
    endfunction

    function automatic logic vs_of(input int unsigned p);
        int unsigned yy = (p / HT) % VT;
        return (yy == 5) ? 1'b1 : 1'b0;
    endfunction

    function automatic logic vid_of(input int unsigned p);
        return ((p % HT) < 8) && (((p / HT) % VT) < 4);
    endfunction

    function automatic exp_t model(input int k, input logic en_v);
        exp_t r;
        int unsigned d  = div_of(k);
        int unsigned p  = p_cnt[k];
        int unsigned xx = p % HT;
        int unsigned yy = (p / HT) % VT;
        r.pt = en_v && ((e_cnt[k] % d) == d - 1);
        r.x  = 5'(xx);
        r.y  = 5'(yy);
`ifdef VGA_SYNC_DLY_EN
        r.hs  = ph[k][1];
        r.vs  = pv[k][1];
        r.vid = pd[k][1];
`else
        r.hs  = hs_of(k, p);
        r.vs  = vs_of(p);
        r.vid = vid_of(p);
`endif
        r.ls = r.pt && (xx == 0);
        r.fs = r.pt && (xx == 0) && (yy == 0);
        return r;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            e_cnt[k] = 0;
            p_cnt[k] = 0;
`ifdef VGA_SYNC_DLY_EN
            for (int s = 0; s < 2; s++) begin
                ph[k][s] = ~hpol_of(k);
                pv[k][s] = 1'b0;
                pd[k][s] = 1'b0;
            end
`endif
        end
    endtask

    // One clock: drive inputs on the falling edge, queue expectations, advance the model at the rising edge.
    task automatic step(input logic r, input logic e);
        exp_t ex0, ex1;
        logic pt[2];
        @(negedge clk_100MHz);
        reset = r;
        en    = e;
        if (r) model_reset();
        ex0 = model(0, e);
        ex1 = model(1, e);
        sbq0.push_back(ex0);
        sbq1.push_back(ex1);
        pt[0] = ex0.pt;
        pt[1] = ex1.pt;
        @(posedge clk_100MHz);
        if (!r) begin
            for (int k = 0; k < 2; k++) begin
                if (e) e_cnt[k] = (e_cnt[k] + 1) % div_of(k);
                if (pt[k]) begin
`ifdef VGA_SYNC_DLY_EN
                    ph[k][1] = ph[k][0];
                    pv[k][1] = pv[k][0];
                    pd[k][1] = pd[k][0];
                    ph[k][0] = hs_of(k, p_cnt[k]);
                    pv[k][0] = vs_of(p_cnt[k]);
                    pd[k][0] = vid_of(p_cnt[k]);
`endif
                    p_cnt[k] = (p_cnt[k] + 1) % FRM;
                end
            end
        end
    endtask

    task automatic cmp(input string nm, input int k, input int act, input int exp_v);
        tests++;
        if (act != exp_v) begin
            failed++;
            $display("FAIL %s dut%0d: got %0d expected %0d at %0t", nm, k, act, exp_v, $time);
        end
    endtask

    task automatic check_dut(input int k, input exp_t ex, input logic pt, input logic [4:0] xa,
                             input logic [4:0] ya, input logic vid, input logic hs, input logic vs,
                             input logic ls, input logic fs);
        cmp("p_tick", k, int'(pt), int'(ex.pt));
        cmp("x", k, int'(xa), int'(ex.x));
        cmp("y", k, int'(ya), int'(ex.y));
        cmp("video_on", k, int'(vid), int'(ex.vid));
        cmp("hsync", k, int'(hs), int'(ex.hs));
        cmp("vsync", k, int'(vs), int'(ex.vs));
        cmp("line_start", k, int'(ls), int'(ex.ls));
        cmp("frame_start", k, int'(fs), int'(ex.fs));
    endtask

    always @(negedge clk_100MHz) begin
        if (mon_on) begin
            #1;
            if (sbq0.size() == 0 || sbq1.size() == 0) begin
                tests++;
                failed++;
                $display("FAIL scoreboard: got empty queue expected an entry at %0t", $time);
            end else begin
                exp_t e0, e1;
                e0 = sbq0.pop_front();
                e1 = sbq1.pop_front();
                check_dut(0, e0, vga0.p_tick, vga0.x, vga0.y, vga0.video_on, vga0.hsync,
                          vga0.vsync, vga0.line_start, vga0.frame_start);
                check_dut(1, e1, vga1.p_tick, vga1.x, vga1.y, vga1.video_on, vga1.hsync,
                          vga1.vsync, vga1.line_start, vga1.frame_start);
            end
        end
    end

    initial begin
        int guard;
        model_reset();
        mon_on = 1'b1;

        repeat (3) step(1'b1, 1'b0);

        // Two full frames of dut0 free-running.
        repeat (2 * FRM * 3 + 20) step(1'b0, 1'b1);

        // Freeze for 37 clocks at dut0 pixel (5,2).
        guard = 0;
        while (p_cnt[0] != 2 * HT + 5 && guard < 2000) begin
            step(1'b0, 1'b1);
            guard++;
        end
        repeat (37) step(1'b0, 1'b0);
        repeat (60) step(1'b0, 1'b1);

        // Reset mid-frame at dut0 pixel (12,3), held for 3 clocks.
        guard = 0;
        while (p_cnt[0] != 3 * HT + 12 && guard < 2000) begin
            step(1'b0, 1'b1);
            guard++;
        end
        repeat (3) step(1'b1, 1'b1);
        repeat (FRM * 3 + 10) step(1'b0, 1'b1);

        // Randomised run/hold/reset traffic.
        for (int i = 0; i < 2000; i++) begin
            int unsigned sel;
            sel = $urandom_range(0, 299);
            if (sel == 0) begin
                repeat ($urandom_range(1, 3)) step(1'b1, 1'($urandom_range(0, 1)));
            end else if (sel < 6) begin
                repeat ($urandom_range(1, 40)) step(1'b0, 1'b0);
            end else begin
                step(1'b0, 1'($urandom_range(0, 7) != 0));
            end
        end

        mon_on = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
